// File: rtl/connect4_pkg.sv
// Shared Connect Four constants and game-FSM encoding, also used by the VGA datapath
// for grid geometry.
package connect4_pkg;

    localparam int unsigned COLS  = 7;
    localparam int unsigned ROWS  = 6;
    localparam int unsigned COL_W = 3;
    localparam int unsigned ROW_W = 3;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned CELLS = ROWS * COLS;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDraw = 2'd1,
        StFull = 2'd2
    } state_e;

endpackage

// File: rtl/board_store.sv
// Board state: per-column fill heights plus occupancy/owner bits, with a write port
// that drops a piece on top of a column and a combinational cell read port.
module board_store
    import connect4_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic [COL_W-1:0] hcol,
    output logic [ROW_W-1:0] hcol_height,
    input  logic             we,
    input  logic [COL_W-1:0] wr_col,
    input  logic             wr_owner,
    input  logic [COL_W-1:0] rd_col,
    input  logic [ROW_W-1:0] rd_row,
    output logic             rd_occ,
    output logic             rd_owner
);

    logic [ROW_W-1:0]           height_q [COLS];
    logic [COLS-1:0][ROWS-1:0]  occ_q;
    logic [COLS-1:0][ROWS-1:0]  owner_q;
    logic [ROW_W-1:0]           wr_row;

    assign wr_row = height_q[wr_col];

    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int c = 0; c < COLS; c++) begin
                height_q[c] <= '0;
            end
            occ_q   <= '0;
            owner_q <= '0;
        end else if (we && (wr_col < COL_W'(COLS)) && (wr_row < ROW_W'(ROWS))) begin
            occ_q[wr_col][wr_row]   <= 1'b1;
            owner_q[wr_col][wr_row] <= wr_owner;
            height_q[wr_col]        <= wr_row + ROW_W'(1);
        end
    end

    // Out-of-range columns report height 0; the FSM rejects them separately.
    always_comb begin
        hcol_height = '0;
        if (hcol < COL_W'(COLS)) begin
            hcol_height = height_q[hcol];
        end
    end

    always_comb begin
        rd_occ   = 1'b0;
        rd_owner = 1'b0;
        if ((rd_col < COL_W'(COLS)) && (rd_row < ROW_W'(ROWS))) begin
            rd_occ   = occ_q[rd_col][rd_row];
            rd_owner = owner_q[rd_col][rd_row];
        end
    end

endmodule

// File: rtl/move_controller.sv
// Connect Four move controller: validates drops against column heights, issues a held
// draw request per accepted move, alternates players and stops once the board is full.
module move_controller
    import connect4_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic [COL_W-1:0] col_sel,
    input  logic             drop,
    input  logic             draw_done,
    output logic             draw_req,
    output logic [COL_W-1:0] location,
    output logic [ROW_W-1:0] decoded_height,
    output logic             player,
    output logic             illegal,
    output logic             board_full,
    input  logic [COL_W-1:0] rd_col,
    input  logic [ROW_W-1:0] rd_row,
    output logic             rd_occ,
    output logic             rd_owner
);

    state_e           state_q, state_d;
    logic             drop_q;
    logic             player_q, player_d;
    logic [COL_W-1:0] location_q, location_d;
    logic [ROW_W-1:0] height_q, height_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             illegal_q, illegal_d;
    logic             drop_rise;
    logic             we;
    logic [ROW_W-1:0] col_height;

    assign drop_rise = drop & ~drop_q;

    board_store u_board (
        .clk         (clk),
        .resetn      (resetn),
        .hcol        (col_sel),
        .hcol_height (col_height),
        .we          (we),
        .wr_col      (location_q),
        .wr_owner    (player_q),
        .rd_col      (rd_col),
        .rd_row      (rd_row),
        .rd_occ      (rd_occ),
        .rd_owner    (rd_owner)
    );

    // drop_q resets high so a drop held through reset must be released first.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q    <= StIdle;
            drop_q     <= 1'b1;
            player_q   <= 1'b0;
            location_q <= '0;
            height_q   <= '0;
            count_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop;
            player_q   <= player_d;
            location_q <= location_d;
            height_q   <= height_d;
            count_q    <= count_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        player_d   = player_q;
        location_d = location_q;
        height_d   = height_q;
        count_d    = count_q;
        illegal_d  = 1'b0;
        we         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (drop_rise) begin
                    if ((col_sel >= COL_W'(COLS)) || (col_height == ROW_W'(ROWS))) begin
                        illegal_d = 1'b1;
                    end else begin
                        location_d = col_sel;
                        height_d   = col_height;
                        state_d    = StDraw;
                    end
                end
            end
            StDraw: begin
                // A drop rising in the same cycle as draw_done is deliberately discarded.
                if (draw_done) begin
                    we       = 1'b1;
                    player_d = ~player_q;
                    count_d  = count_q + CNT_W'(1);
                    state_d  = (count_d == CNT_W'(CELLS)) ? StFull : StIdle;
                end
            end
            StFull: begin
                state_d = StFull;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign draw_req       = (state_q == StDraw);
    assign board_full     = (state_q == StFull);
    assign location       = location_q;
    assign decoded_height = height_q;
    assign player         = player_q;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed self-checking bench for move_controller with hand-computed expectations.
module tb_move_controller;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] col_sel;
    logic       drop;
    logic       draw_done;
    logic       draw_req;
    logic [2:0] location;
    logic [2:0] decoded_height;
    logic       player;
    logic       illegal;
    logic       board_full;
    logic [2:0] rd_col;
    logic [2:0] rd_row;
    logic       rd_occ;
    logic       rd_owner;

    int n_vec = 0;
    int n_err = 0;

    move_controller dut (
        .clk            (clk),
        .resetn         (resetn),
        .col_sel        (col_sel),
        .drop           (drop),
        .draw_done      (draw_done),
        .draw_req       (draw_req),
        .location       (location),
        .decoded_height (decoded_height),
        .player         (player),
        .illegal        (illegal),
        .board_full     (board_full),
        .rd_col         (rd_col),
        .rd_row         (rd_row),
        .rd_occ         (rd_occ),
        .rd_owner       (rd_owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b1;
        drop      = 1'b0;
        draw_done = 1'b0;
        step();
        step();
        resetn = 1'b0;
        step();
    endtask

    task automatic do_drop(input int col);
        col_sel = 3'(col);
        drop    = 1'b1;
        step();
        drop = 1'b0;
    endtask

    task automatic do_done();
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
    endtask

    task automatic read_cell(input int c, input int r, output int occ, output int own);
        rd_col = 3'(c);
        rd_row = 3'(r);
        #1;
        occ = int'(rd_occ);
        own = int'(rd_owner);
    endtask

    initial begin
        int occ, own;
        col_sel = '0;
        rd_col  = '0;
        rd_row  = '0;
        do_reset();

        check("rst_draw_req", draw_req, 0);
        check("rst_player", player, 0);
        check("rst_location", location, 0);
        check("rst_height", decoded_height, 0);
        check("rst_illegal", illegal, 0);
        check("rst_full", board_full, 0);

        // First move in column 3.
        do_drop(3);
        check("m1_req", draw_req, 1);
        check("m1_loc", location, 3);
        check("m1_hgt", decoded_height, 0);
        check("m1_player", player, 0);
        read_cell(3, 0, occ, own);
        check("m1_rd_before", occ, 0);
        do_done();
        check("m1_req_drop", draw_req, 0);
        check("m1_player_tgl", player, 1);
        read_cell(3, 0, occ, own);
        check("m1_rd_occ", occ, 1);
        check("m1_rd_own", own, 0);

        // Fill column 2, owners alternate starting at player 1.
        for (int i = 0; i < 6; i++) begin
            do_drop(2);
            check($sformatf("c2_hgt%0d", i), decoded_height, i);
            check($sformatf("c2_ply%0d", i), player, (i % 2 == 0) ? 1 : 0);
            do_done();
        end
        do_drop(2);
        check("c2_full_illegal", illegal, 1);
        check("c2_full_noreq", draw_req, 0);
        step();
        check("c2_illegal_pulse", illegal, 0);
        check("c2_player_keep", player, 1);
        read_cell(2, 5, occ, own);
        check("c2_top_occ", occ, 1);
        check("c2_top_own", own, 0);

        // Out-of-range column.
        do_drop(7);
        check("c7_illegal", illegal, 1);
        check("c7_noreq", draw_req, 0);
        step();
        check("c7_pulse", illegal, 0);
        do_drop(6);
        check("c7_after_hgt", decoded_height, 0);
        do_done();

        // Drop held through reset must be released before it counts.
        resetn = 1'b1;
        col_sel = 3'd0;
        drop = 1'b1;
        step();
        step();
        resetn = 1'b0;
        step();
        check("held_noreq", draw_req, 0);
        read_cell(3, 0, occ, own);
        check("held_board_clr", occ, 0);
        drop = 1'b0;
        step();
        drop = 1'b1;
        step();
        check("rel_req", draw_req, 1);
        drop = 1'b0;
        step();
        drop = 1'b1;
        step();
        check("draw_ignores_drop", draw_req, 1);
        do_done();
        drop = 1'b0;
        check("one_move_req", draw_req, 0);
        read_cell(0, 0, occ, own);
        check("one_move_r0", occ, 1);
        read_cell(0, 1, occ, own);
        check("one_move_r1", occ, 0);
        step();

        // Drop rise coincident with draw_done is discarded.
        do_drop(0);
        check("coin_req", draw_req, 1);
        check("coin_hgt", decoded_height, 1);
        step();
        drop      = 1'b1;
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
        check("coin_done", draw_req, 0);
        step();
        check("coin_discard", draw_req, 0);
        drop = 1'b0;
        step();

        // Fill the whole board column by column round robin.
        do_reset();
        for (int k = 0; k < 42; k++) begin
            do_drop(k % 7);
            check($sformatf("fill_hgt%0d", k), decoded_height, k / 7);
            check($sformatf("fill_ply%0d", k), player, k % 2);
            if (k == 41) begin
                check("fill_not_full", board_full, 0);
            end
            do_done();
        end
        check("fill_full", board_full, 1);
        check("fill_noreq", draw_req, 0);
        drop = 1'b1;
        step();
        check("full_drop_noreq", draw_req, 0);
        check("full_drop_noill", illegal, 0);
        drop = 1'b0;
        step();
        check("full_sticky", board_full, 1);
        read_cell(6, 5, occ, own);
        check("full_r65_occ", occ, 1);
        check("full_r65_own", own, 1);
        read_cell(1, 0, occ, own);
        check("full_r10_own", own, 1);
        read_cell(7, 0, occ, own);
        check("rd_col_oob", occ, 0);
        read_cell(0, 6, occ, own);
        check("rd_row_oob", occ, 0);

        // Reset mid-draw, then a late draw_done.
        do_reset();
        do_drop(4);
        check("mid_req", draw_req, 1);
        resetn = 1'b1;
        step();
        check("mid_rst_req", draw_req, 0);
        resetn    = 1'b0;
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
        check("late_done_req", draw_req, 0);
        check("late_done_player", player, 0);
        read_cell(4, 0, occ, own);
        check("late_done_occ", occ, 0);
        do_drop(4);
        check("late_after_hgt", decoded_height, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/move_controller.md
Name: move_controller

Overview:
- Upstream game-logic stage for the Connect Four VGA drawer.
- Accepts a player's column choice and a drop strobe, checks the move against per-column fill heights, and records occupancy and owner.
- Issues a draw request (location, height, player) to the drawing control/datapath and holds it until that stage reports completion.
- Alternates players after each move and stops accepting moves once the board is full.

Parameters:
- COLS, 7, number of board columns
- ROWS, 6, number of board rows
- COL_W, 3, width of column index
- ROW_W, 3, width of row/height index
- CNT_W, 6, width of move counter (must hold ROWS*COLS)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- resetn  in  1  synchronous, active-high reset (asserted = 1 clears block)
- col_sel  in  COL_W  requested column, from switches
- drop  in  1  level drop request from switch; acted on at rising edge only
- draw_done  in  1  one-cycle pulse from drawer: current piece fully plotted
- draw_req  out  1  high while a piece awaits drawing (drives drawer go)
- location  out  COL_W  column of piece being drawn
- decoded_height  out  ROW_W  row of piece being drawn (0 = bottom)
- player  out  1  owner of piece being drawn / player to move when idle
- illegal  out  1  one-cycle pulse: rejected move
- board_full  out  1  sticky: all ROWS*COLS cells occupied
- rd_col  in  COL_W  board read column
- rd_row  in  ROW_W  board read row
- rd_occ  out  1  combinational: cell (rd_col, rd_row) occupied
- rd_owner  out  1  combinational: owner of that cell (0 if unoccupied)

Behaviour:
- Reset values:
  - state IDLE; all heights 0; all occupancy/owner bits 0; move count 0.
  - player 0, location 0, decoded_height 0.
  - draw_req, illegal and board_full all 0.
  - drop_q (registered drop) resets to 1, so a drop held through reset must be released before it counts.
- Reset mid-draw: next cycle draw_req is 0, and any draw_done arriving later is ignored.
- Drop edge: drop_rise = drop & ~drop_q; drop_q <= drop every cycle.
- States:
  - IDLE: on drop_rise, check the requested column.
    - If col_sel >= COLS or height[col_sel] == ROWS: illegal = 1 for exactly the next cycle; stay IDLE; no state change.
    - Else: latch location <= col_sel and decoded_height <= height[col_sel]; go to DRAW.
  - DRAW: draw_req = 1 (registered, high on first DRAW cycle). location, decoded_height and player are held constant. On draw_done, the same edge:
    - sets occupied[location][decoded_height] = 1 and owner = player;
    - increments height[location] and the move count;
    - toggles player;
    - drops draw_req to 0;
    - goes to FULL if the new count == ROWS*COLS, else IDLE.
  - FULL: board_full = 1; drop ignored (no illegal pulse); remains until reset.
- Latency: drop rise to draw_req high = 1 cycle. draw_done to next acceptable drop = 1 cycle (IDLE).
- Ignored events:
  - drop_rise in DRAW or FULL is ignored, not queued.
  - draw_done outside DRAW is ignored.
  - drop_rise and draw_done in the same DRAW cycle: the move completes and the drop is discarded.
- Width rules:
  - heights are ROW_W+1 bits conceptually (range 0..ROWS); ROW_W=3 is sufficient for ROWS=6.
  - col_sel values 7 (COLS=7) is out of range → illegal.
- Read port: rd_col >= COLS or rd_row >= ROWS returns rd_occ = 0, rd_owner = 0.
- Board storage updates only on the draw_done edge, so the read port shows the new piece the cycle after draw_done.

Decomposition:
- Shared package connect4_pkg:
  - COLS, ROWS, COL_W, ROW_W, CNT_W;
  - state encoding IDLE=2'd0, DRAW=2'd1, FULL=2'd2;
  - the same constants are also used by the VGA datapath for grid geometry.
- Sub-module board_store:
  - holds the per-column height counters and the occupancy/owner arrays;
  - write interface: col, we;
  - outputs the column height and the read port.
- move_controller keeps the FSM, edge detect, player toggle and move counter.

Test Plan:
- Reset, drop rise with col_sel=3 → next cycle draw_req=1, location=3, decoded_height=0, player=0; pulse draw_done → draw_req=0, player=1, rd(3,0) occ=1 owner=0.
- Six accepted drops in column 2, then a seventh → illegal pulses 1 cycle, draw_req stays 0, player unchanged.
- col_sel=7 with drop rise → illegal=1 one cycle, no height change.
- Hold drop high across reset release → no draw_req. Toggle drop 0→1 during DRAW → ignored; then a single draw_done → one move recorded only.
- Fill all 42 cells alternating columns → board_full=1 after the 42nd draw_done; further drops give no draw_req and no illegal.
- Assert resetn in DRAW with a draw_done one cycle later → all heights 0, draw_req 0, the late draw_done has no effect, rd(col,0) occ=0.
